seq_divider: RTL and testbench

//  Multi-cycle restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient + remainder.

---
 rtl/seq_divider_if.sv | 25 ++
 rtl/seq_divider.sv | 122 ++++++++++++
 tb/tb_seq_divider.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Handshake and result bundle for the sequential restoring divider.
// The bench drives through master; the divider core attaches as slave.
interface seq_divider_if #(
    parameter int W = 8
);
    logic             start;
    logic [2*W-1:0]   dividend;
    logic [W-1:0]     divisor;
    logic [W-1:0]     quotient;
    logic [W-1:0]     remainder;
    logic             done_flag;
    logic             div_zero;
    logic             overflow;
    logic [2:0]       state;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, done_flag, div_zero, overflow, state
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, done_flag, div_zero, overflow, state
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit per clock.
// Shares the start/done_flag handshake and 3-bit state display code with the sequential multiplier.
module seq_divider #(
    parameter int W = 8
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    localparam int CW = $clog2(W);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CALC = 3'd1,
        DONE = 3'd2,
        ERR  = 3'd3
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   r_q, r_d, q_q, q_d, dvs_q, dvs_d;
    logic [W-1:0]   quo_q, quo_d, rem_q, rem_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           done_q, done_d, dz_q, dz_d, ov_q, ov_d;

    logic [W:0]     t;
    logic           ge;
    logic [W-1:0]   r_step, q_step;

    // Because R < divisor, T - divisor always fits in W bits, so the carry bit is dropped.
    always_comb begin
        t      = {r_q, q_q[W-1]};
        ge     = (t >= {1'b0, dvs_q});
        r_step = ge ? (t[W-1:0] - dvs_q) : t[W-1:0];
        q_step = {q_q[W-2:0], ge};
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        done_d  = done_q;
        dz_d    = dz_q;
        ov_d    = ov_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (bus.start) begin
                    done_d = 1'b0;
                    dz_d   = 1'b0;
                    ov_d   = 1'b0;
                    dvs_d  = bus.divisor;
                    r_d    = bus.dividend[2*W-1:W];
                    q_d    = bus.dividend[W-1:0];
                    if (bus.divisor == '0) begin
                        state_d = ERR;
                        dz_d    = 1'b1;
                        done_d  = 1'b1;
                        quo_d   = '0;
                        rem_d   = '0;
                    end else if (bus.dividend[2*W-1:W] >= bus.divisor) begin
                        state_d = ERR;
                        ov_d    = 1'b1;
                        done_d  = 1'b1;
                        quo_d   = '0;
                        rem_d   = '0;
                    end else begin
                        state_d = CALC;
                        cnt_d   = CW'(W - 1);
                    end
                end
            end
            CALC: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    quo_d   = q_step;
                    rem_d   = r_step;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
        end
    end

    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
    assign bus.done_flag = done_q;
    assign bus.div_zero  = dz_q;
    assign bus.overflow  = ov_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: expected results come from an arithmetic reference model
// queued at launch time and popped when the divider signals completion.
module tb_seq_divider;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
        logic [2:0]   st;
    } exp_t;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;
    exp_t sb[$];

    seq_divider_if #(.W(W)) dif ();

    seq_divider #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step_edge();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain integer division with the two error conditions.
    task automatic push_expected(input logic [2*W-1:0] dd, input logic [W-1:0] dv);
        exp_t e;
        int unsigned quo;
        e = '{q: '0, r: '0, dz: 1'b0, ov: 1'b0, st: 3'd2};
        if (dv == 0) begin
            e.dz = 1'b1;
            e.st = 3'd3;
        end else begin
            quo = int'(dd) / int'(dv);
            if (quo > (2**W - 1)) begin
                e.ov = 1'b1;
                e.st = 3'd3;
            end else begin
                e.q = W'(quo);
                e.r = W'(int'(dd) % int'(dv));
            end
        end
        sb.push_back(e);
    endtask

    // Drives one launch edge, then scrambles operands to prove they were latched.
    task automatic apply_stimulus(input logic [2*W-1:0] dd, input logic [W-1:0] dv);
        dif.dividend = dd;
        dif.divisor  = dv;
        dif.start    = 1'b1;
        push_expected(dd, dv);
        step_edge();
        dif.start    = 1'b0;
        dif.dividend = 16'($urandom);
        dif.divisor  = 8'($urandom);
    endtask

    task automatic check_output(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check_val({tag, "_sb_empty"}, 16'd1, 16'd0);
        end else begin
            e = sb.pop_front();
            check_val({tag, "_done"},  16'(dif.done_flag), 16'd1);
            check_val({tag, "_state"}, 16'(dif.state),     16'(e.st));
            check_val({tag, "_q"},     16'(dif.quotient),  16'(e.q));
            check_val({tag, "_r"},     16'(dif.remainder), 16'(e.r));
            check_val({tag, "_dz"},    16'(dif.div_zero),  16'(e.dz));
            check_val({tag, "_ov"},    16'(dif.overflow),  16'(e.ov));
        end
    endtask

    // Waits (bounded) for done_flag, checks the edge count from the launch edge, then the result.
    task automatic finish_op(input string tag, input int edges_so_far, input int exp_lat);
        int edges;
        edges = edges_so_far;
        while (!dif.done_flag && edges < 20) begin
            step_edge();
            edges++;
        end
        check_val({tag, "_latency"}, 16'(edges), 16'(exp_lat));
        check_output(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_state"}, 16'(dif.state),     16'd0);
        check_val({tag, "_q"},     16'(dif.quotient),  16'd0);
        check_val({tag, "_r"},     16'(dif.remainder), 16'd0);
        check_val({tag, "_done"},  16'(dif.done_flag), 16'd0);
        check_val({tag, "_dz"},    16'(dif.div_zero),  16'd0);
        check_val({tag, "_ov"},    16'(dif.overflow),  16'd0);
    endtask

    initial begin
        exp_t discard;
        compared     = 0;
        mismatched   = 0;
        rst          = 1'b0;
        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        step_edge();
        step_edge();
        check_all_zero("reset");
        rst = 1'b1;
        step_edge();

        $display("[TB] test 1: 1000 / 25 with state trace");
        apply_stimulus(16'd1000, 8'd25);
        for (int i = 1; i <= 8; i++) begin
            check_val($sformatf("t1_state_e%0d", i), 16'(dif.state), 16'd1);
            step_edge();
        end
        check_output("t1");

        $display("[TB] test 2: 0x7FFF / 0xFF");
        apply_stimulus(16'h7FFF, 8'hFF);
        finish_op("t2", 1, 9);

        $display("[TB] test 3: divide by zero");
        apply_stimulus(16'h1234, 8'h00);
        finish_op("t3", 1, 1);

        $display("[TB] test 4: overflow at upper byte == divisor");
        apply_stimulus(16'h1234, 8'h12);
        finish_op("t4", 1, 1);

        $display("[TB] test 5: start ignored during CALC, then relaunch from DONE");
        apply_stimulus(16'd1000, 8'd25);
        step_edge();
        step_edge();
        dif.dividend = 16'd9;
        dif.divisor  = 8'd3;
        dif.start    = 1'b1;
        step_edge();
        dif.start    = 1'b0;
        check_val("t5_still_calc", 16'(dif.state), 16'd1);
        finish_op("t5a", 4, 9);
        apply_stimulus(16'd9, 8'd3);
        finish_op("t5b", 1, 9);

        $display("[TB] test 6: reset mid-CALC, then relaunch");
        apply_stimulus(16'd500, 8'd7);
        step_edge();
        step_edge();
        check_val("t6_hold_q", 16'(dif.quotient), 16'd3);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("t6_abort");
        if (sb.size() != 0) discard = sb.pop_front();
        rst = 1'b1;
        step_edge();
        check_val("t6_idle_after", 16'(dif.state), 16'd0);
        apply_stimulus(16'd500, 8'd7);
        finish_op("t6", 1, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
